// File: rtl/prog_loader_pkg.sv
// Shared constants, FSM state type and checksum helper for the program loader.
// The CHK state exists only when PROG_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

  localparam int DW = 32;

  localparam logic [7:0] CMD_LOAD_IMEM = 8'h01;
  localparam logic [7:0] CMD_LOAD_RF   = 8'h02;
  localparam logic [7:0] CMD_RUN       = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_COUNT   = 3'd2,
    ST_DATA    = 3'd3,
    ST_DISCARD = 3'd4
`ifdef PROG_LOADER_CHECKSUM_EN
    , ST_CHK   = 3'd5
`endif
  } state_t;

  // Running frame checksum is a plain byte-wise XOR.
  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input plus instruction-memory / register-file write ports and core control.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int IMEM_AW = 8,
  parameter int RF_AW   = 5
);
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [DW-1:0]      imem_wdata;
  logic               rf_we;
  logic [RF_AW-1:0]   rf_addr;
  logic [DW-1:0]      rf_wdata;
  logic               core_reset;
  logic               busy;
  logic               error;

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata,
           rf_we, rf_addr, rf_wdata, core_reset, busy, error
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata,
           rf_we, rf_addr, rf_wdata, core_reset, busy, error
  );
endinterface

// File: rtl/prog_loader_word_assembler.sv
// Collects four bytes (MSB first) into a word; word_valid pulses combinationally with the 4th byte.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          word_valid,
  output logic [DW-1:0] word
);
  logic [23:0] shift_r;
  logic [1:0]  idx_r;

  // Byte shift register and position counter.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_r <= 24'd0;
      idx_r   <= 2'd0;
    end else if (byte_valid) begin
      shift_r <= {shift_r[15:0], byte_data};
      idx_r   <= idx_r + 2'd1;
    end else begin
      shift_r <= shift_r;
      idx_r   <= idx_r;
    end
  end

  assign word_valid = byte_valid & (idx_r == 2'd3);
  assign word       = {shift_r, byte_data};

endmodule

// File: rtl/prog_loader.sv
// Host byte-stream loader for instruction memory and register file; holds core in reset until RUN.
// Optional trailing XOR checksum byte per load frame: define PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IMEM_AW = 8,
  parameter int RF_AW   = 5
)(
  input logic         clk,
  input logic         reset,
  prog_loader_if.slave bus
);

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t ST_END = ST_CHK;
`else
  localparam state_t ST_END = ST_IDLE;
`endif

  state_t             state_r;
  logic               in_ready_r;
  logic               imem_we_r;
  logic [IMEM_AW-1:0] imem_addr_r;
  logic [DW-1:0]      imem_wdata_r;
  logic               rf_we_r;
  logic [RF_AW-1:0]   rf_addr_r;
  logic [DW-1:0]      rf_wdata_r;
  logic               core_reset_r;
  logic               busy_r;
  logic               error_r;
  logic [7:0]         cmd_r;
  logic               bad_r;
  logic [IMEM_AW-1:0] imem_ptr_r;
  logic [RF_AW-1:0]   rf_ptr_r;
  logic [7:0]         cnt_r;
  logic [9:0]         disc_r;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]         chk_r;
`endif

  logic          acc_s;
  logic          word_valid_s;
  logic [DW-1:0] word_s;
  logic          rf_addr_bad_s;

  assign acc_s         = bus.in_valid & in_ready_r;
  assign rf_addr_bad_s = ({24'd0, bus.in_data} >= (32'd1 << RF_AW));

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (state_r != ST_DATA),
    .byte_valid (acc_s && (state_r == ST_DATA)),
    .byte_data  (bus.in_data),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

  // Frame FSM with address/count tracking and registered write strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      in_ready_r   <= 1'b0;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= '0;
      imem_wdata_r <= 32'd0;
      rf_we_r      <= 1'b0;
      rf_addr_r    <= '0;
      rf_wdata_r   <= 32'd0;
      core_reset_r <= 1'b1;
      busy_r       <= 1'b0;
      error_r      <= 1'b0;
      cmd_r        <= 8'd0;
      bad_r        <= 1'b0;
      imem_ptr_r   <= '0;
      rf_ptr_r     <= '0;
      cnt_r        <= 8'd0;
      disc_r       <= 10'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_r        <= 8'd0;
`endif
    end else begin
      in_ready_r <= 1'b1;
      imem_we_r  <= 1'b0;
      rf_we_r    <= 1'b0;
      if (acc_s) begin
`ifdef PROG_LOADER_CHECKSUM_EN
        chk_r <= chk_fold(chk_r, bus.in_data);
`endif
        case (state_r)
          ST_IDLE: begin
            if ((bus.in_data == CMD_LOAD_IMEM) || (bus.in_data == CMD_LOAD_RF)) begin
              cmd_r        <= bus.in_data;
              core_reset_r <= 1'b1;
              state_r      <= ST_ADDR;
              busy_r       <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
              chk_r        <= bus.in_data;
`endif
            end else if (bus.in_data == CMD_RUN) begin
              core_reset_r <= 1'b0;
            end else begin
              error_r <= 1'b1;
            end
          end
          ST_ADDR: begin
            imem_ptr_r <= IMEM_AW'(bus.in_data);
            rf_ptr_r   <= RF_AW'(bus.in_data);
            bad_r      <= (cmd_r == CMD_LOAD_RF) && rf_addr_bad_s;
            if ((cmd_r == CMD_LOAD_RF) && rf_addr_bad_s) begin
              error_r <= 1'b1;
            end
            state_r <= ST_COUNT;
          end
          ST_COUNT: begin
            cnt_r <= bus.in_data;
            if (bus.in_data == 8'd0) begin
              state_r <= ST_END;
              busy_r  <= (ST_END != ST_IDLE);
            end else if (bad_r) begin
              disc_r  <= {bus.in_data, 2'b00};
              state_r <= ST_DISCARD;
            end else begin
              state_r <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (word_valid_s) begin
              if (cmd_r == CMD_LOAD_IMEM) begin
                imem_we_r    <= 1'b1;
                imem_addr_r  <= imem_ptr_r;
                imem_wdata_r <= word_s;
                imem_ptr_r   <= imem_ptr_r + IMEM_AW'(1);
              end else begin
                rf_we_r    <= 1'b1;
                rf_addr_r  <= rf_ptr_r;
                rf_wdata_r <= word_s;
                rf_ptr_r   <= rf_ptr_r + RF_AW'(1);
              end
              cnt_r <= cnt_r - 8'd1;
              if (cnt_r == 8'd1) begin
                state_r <= ST_END;
                busy_r  <= (ST_END != ST_IDLE);
              end
            end
          end
          ST_DISCARD: begin
            disc_r <= disc_r - 10'd1;
            if (disc_r == 10'd1) begin
              state_r <= ST_END;
              busy_r  <= (ST_END != ST_IDLE);
            end
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          ST_CHK: begin
            if (bus.in_data != chk_r) begin
              error_r <= 1'b1;
            end
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
`endif
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.imem_we    = imem_we_r;
  assign bus.imem_addr  = imem_addr_r;
  assign bus.imem_wdata = imem_wdata_r;
  assign bus.rf_we      = rf_we_r;
  assign bus.rf_addr    = rf_addr_r;
  assign bus.rf_wdata   = rf_wdata_r;
  assign bus.core_reset = core_reset_r;
  assign bus.busy       = busy_r;
  assign bus.error      = error_r;

endmodule
